dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported synchronous data memory between the core's MEM stage and an external requester (debug/program loader or DMA). It decides per cycle which requester drives the memory's enable, address, write data and byte write enables. It routes the next-cycle read data back to the owner of the read. A starvation counter guarantees the external port progress while the core keeps the memory busy.

## Interface
- STARVE_MAX, 4: consecutive contested core grants after which the external port wins the next conflict (legal range 1..15)
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- core_req  in  1  core memory access request (load or store) this cycle
- core_wen  in  4  core byte write enables, 4'b0000 = read
- core_addr  in  32  core byte address
- core_wdata  in  32  core write data, already lane-aligned
- core_stall  out  1  core access not granted this cycle; hold pipeline
- core_rvalid  out  1  core read data valid
- core_rdata  out  32  core read data
- ext_req  in  1  external request; must be held with stable fields until ext_gnt
- ext_wen  in  4  external byte write enables, 0 = read
- ext_addr  in  32  external byte address
- ext_wdata  in  32  external write data
- ext_gnt  out  1  external access accepted this cycle
- ext_rvalid  out  1  external read data valid
- ext_rdata  out  32  external read data
- mem_en  out  1  memory enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_wen  out  4  memory byte write enables
- mem_rdata  in  32  memory read data, valid one cycle after a read access

## Operation
- Priority FSM, 2 states: CORE_PRI (reset) and EXT_PRI.
- Grant (combinational):
  - Only one requester: that requester wins.
  - Both request in CORE_PRI: the core wins.
  - Both request in EXT_PRI: ext wins.
- core_stall = core_req & ~core_gnt. ext_gnt = ext_req & ext wins.
- Memory drive:
  - Granted requester's addr/wdata/wen go to mem_*. mem_en = core_gnt | ext_gnt.
  - When idle, mem_en=0, mem_wen=0, addr/wdata=0.
- Starvation counter (4 bit):
  - Increments on each cycle in CORE_PRI where both request and the core wins.
  - Clears when ext_gnt or ~ext_req.
  - Saturates at 15.
- Transitions:
  - CORE_PRI -> EXT_PRI when the counter increment reaches STARVE_MAX.
  - EXT_PRI -> CORE_PRI on ext_gnt, which also clears the counter.
  - EXT_PRI with ~ext_req (withdrawn, protocol violation) -> CORE_PRI.
- Read return:
  - Registered rd_owner ∈ {NONE, CORE, EXT} is set on a granted access with wen==0, else NONE.
  - core_rvalid = (rd_owner==CORE). ext_rvalid = (rd_owner==EXT).
  - Both rdata outputs pass mem_rdata through; consumers qualify with rvalid.
- Writes produce no rvalid. Write-then-read to the same address in consecutive cycles returns the new data (memory ordering).

## Timing
- Grant, stall and mem_* are zero-latency combinational from the requests and the FSM state.
- Read latency: request granted in cycle N -> rvalid/rdata in cycle N+1. Back-to-back reads (either owner, alternating allowed) give one result per cycle.
- Reset values (asynchronous):
  - FSM = CORE_PRI, counter = 0, rd_owner = NONE.
  - core_rvalid = ext_rvalid = 0.
  - With no requests: core_stall = 0, ext_gnt = 0, mem_en = 0, mem_wen = 0.
- Reset asserted mid-read: the pending rvalid is dropped. No rvalid appears after rstn deasserts.
- A core request with no ext_req is never stalled.
- Ext worst-case wait under continuous core traffic: STARVE_MAX cycles, granted on the following cycle.
- Simultaneous grant of both requesters is forbidden (checked by assertion).

## Test plan
- Core-only read of 0x10 (mem holds 0xDEADBEEF) -> mem_en=1, mem_wen=0, core_stall=0. Next cycle core_rvalid=1, core_rdata=0xDEADBEEF, ext_rvalid=0.
- Ext-only write: 0xA5A5A5A5, wen=4'b1111, addr 0x400. Then ext read of 0x400 -> ext_gnt both cycles; ext_rvalid the cycle after the read with 0xA5A5A5A5.
- Both request continuously, STARVE_MAX=4 -> core granted cycles 0-3, ext_gnt cycle 4 with core_stall=1, core granted again cycle 5.
- Alternating grants core read 0x0 then ext read 0x4 -> rvalid toggles core then ext on consecutive cycles with the correct data on each.
- rstn pulsed low the cycle after a granted core read -> core_rvalid stays 0. FSM and counter return to CORE_PRI/0.
- Store byte core_wen=4'b0100 at 0x22 -> mem_wen=4'b0100, no rvalid next cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bus bundle between core, external requester, data memory and arbiter
// Purpose: groups the core request/response, external request/response and
//          memory drive signals of dmem_arbiter.
// Modports:
//   slave  : the arbiter's view (requests and mem_rdata in; grants, responses, mem drive out)
//   master : the surrounding system's view (core, external requester, memory)
interface dmem_arbiter_if;
  logic        core_req;
  logic [3:0]  core_wen;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_stall;
  logic        core_rvalid;
  logic [31:0] core_rdata;

  logic        ext_req;
  logic [3:0]  ext_wen;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;

  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wen;
  logic [31:0] mem_rdata;

  modport slave (
    input  core_req, core_wen, core_addr, core_wdata,
    output core_stall, core_rvalid, core_rdata,
    input  ext_req, ext_wen, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_en, mem_addr, mem_wdata, mem_wen,
    input  mem_rdata
  );

  modport master (
    output core_req, core_wen, core_addr, core_wdata,
    input  core_stall, core_rvalid, core_rdata,
    output ext_req, ext_wen, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_en, mem_addr, mem_wdata, mem_wen,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter sharing the single-ported data memory
// Purpose: per cycle grants the memory to the core MEM stage or the external
//          requester, drives mem_* from the winner and routes next-cycle read
//          data back to the owner of the read. A starvation counter forces an
//          external grant after STARVE_MAX consecutive contested core grants.
// Ports:
//   clk   : system clock, all state on rising edge
//   rstn  : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave (core_*, ext_*, mem_* signals)
// Parameters:
//   STARVE_MAX : contested core grants before the external port wins (1..15)
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rstn,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {CORE_PRI = 1'b0, EXT_PRI = 1'b1} pri_e;
  typedef enum logic [1:0] {RD_NONE = 2'd0, RD_CORE = 2'd1, RD_EXT = 2'd2} rd_owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  pri_e       state;
  pri_e       state_nxt;
  logic [3:0] starve_cnt;
  logic [3:0] starve_inc;
  rd_owner_e  rd_owner;
  logic       contested;
  logic       core_gnt;
  logic       ext_gnt;

  // A conflict the core wins: only possible while the core holds priority.
  assign contested  = (state == CORE_PRI) && bus.core_req && bus.ext_req;
  assign starve_inc = (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= CORE_PRI;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      CORE_PRI: if (contested && (starve_inc >= STARVE_LIM)) state_nxt = EXT_PRI;
      // Leaves on the external grant, or if the request was withdrawn.
      EXT_PRI:  if (ext_gnt || !bus.ext_req) state_nxt = CORE_PRI;
      default:  state_nxt = CORE_PRI;
    endcase
  end

  // Output logic: grants and memory drive
  always_comb begin
    ext_gnt       = 1'b0;
    core_gnt      = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wen   = 4'h0;
    if (bus.ext_req && (!bus.core_req || (state == EXT_PRI))) begin
      ext_gnt = 1'b1;
    end
    core_gnt = bus.core_req && !ext_gnt;
    if (core_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.core_addr;
      bus.mem_wdata = bus.core_wdata;
      bus.mem_wen   = bus.core_wen;
    end else if (ext_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
      bus.mem_wen   = bus.ext_wen;
    end
  end

  assign bus.core_stall = bus.core_req && !core_gnt;
  assign bus.ext_gnt    = ext_gnt;

  // Starvation counter: counts consecutive contested core grants while the
  // external requester keeps asking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= 4'h0;
    end else if (ext_gnt || !bus.ext_req) begin
      starve_cnt <= 4'h0;
    end else if (contested) begin
      starve_cnt <= starve_inc;
    end
  end

  // Read return: the memory answers one cycle after the access, so remember
  // who issued the read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_owner <= RD_NONE;
    end else if (core_gnt && (bus.core_wen == 4'h0)) begin
      rd_owner <= RD_CORE;
    end else if (ext_gnt && (bus.ext_wen == 4'h0)) begin
      rd_owner <= RD_EXT;
    end else begin
      rd_owner <= RD_NONE;
    end
  end

  assign bus.core_rvalid = (rd_owner == RD_CORE);
  assign bus.ext_rvalid  = (rd_owner == RD_EXT);
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.ext_rdata   = bus.mem_rdata;

  a_single_grant: assert property (@(posedge clk) disable iff (!rstn) !(core_gnt && ext_gnt));

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
// Purpose: directed scenarios plus randomized traffic checked each cycle
//          against a grant/read-return reference model.
// Ports: none (top-level bench).
module tb_dmem_arbiter;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Environment memory: synchronous single-port RAM.
  logic [31:0] mem_arr [0:511];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wen != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wen[b]) mem_arr[bus.mem_addr[10:2]][b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
      end else begin
        bus.mem_rdata <= mem_arr[bus.mem_addr[10:2]];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:511];
  int          streak;
  bit          pend_v;
  bit          pend_ext;
  logic [31:0] pend_data;
  bit          model_ext_gnt;

  // Stimulus
  bit          c_req, e_req;
  logic [3:0]  c_wen, e_wen;
  logic [31:0] c_addr, c_wdata, e_addr, e_wdata;

  // Observed at the last cycle's sample point
  bit          obs_stall, obs_ext_gnt, obs_core_rvalid, obs_ext_rvalid, obs_mem_en;
  logic [3:0]  obs_mem_wen;
  logic [31:0] obs_core_rdata, obs_ext_rdata;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    bus.core_req   = c_req;
    bus.core_wen   = c_wen;
    bus.core_addr  = c_addr;
    bus.core_wdata = c_wdata;
    bus.ext_req    = e_req;
    bus.ext_wen    = e_wen;
    bus.ext_addr   = e_addr;
    bus.ext_wdata  = e_wdata;
  endtask

  // One clock cycle: drive, check at the negedge, advance model at the posedge.
  task automatic cycle();
    bit          ext_win, core_win, exp_en;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wen;
    drive_inputs();
    @(negedge clk);
    ext_win  = e_req && (!c_req || (streak >= STARVE_MAX));
    core_win = c_req && !ext_win;
    exp_en    = core_win || ext_win;
    exp_addr  = core_win ? c_addr  : (ext_win ? e_addr  : 32'h0);
    exp_wdata = core_win ? c_wdata : (ext_win ? e_wdata : 32'h0);
    exp_wen   = core_win ? c_wen   : (ext_win ? e_wen   : 4'h0);

    obs_stall       = bus.core_stall;
    obs_ext_gnt     = bus.ext_gnt;
    obs_core_rvalid = bus.core_rvalid;
    obs_ext_rvalid  = bus.ext_rvalid;
    obs_core_rdata  = bus.core_rdata;
    obs_ext_rdata   = bus.ext_rdata;
    obs_mem_en      = bus.mem_en;
    obs_mem_wen     = bus.mem_wen;

    check("core_stall", 32'(bus.core_stall), 32'(c_req && !core_win));
    check("ext_gnt",    32'(bus.ext_gnt),    32'(ext_win));
    check("mem_en",     32'(bus.mem_en),     32'(exp_en));
    check("mem_wen",    32'(bus.mem_wen),    32'(exp_wen));
    check("mem_addr",   bus.mem_addr,        exp_addr);
    check("mem_wdata",  bus.mem_wdata,       exp_wdata);
    check("core_rvalid", 32'(bus.core_rvalid), 32'(pend_v && !pend_ext));
    check("ext_rvalid",  32'(bus.ext_rvalid),  32'(pend_v && pend_ext));
    if (pend_v && !pend_ext) check("core_rdata", bus.core_rdata, pend_data);
    if (pend_v && pend_ext)  check("ext_rdata",  bus.ext_rdata,  pend_data);

    @(posedge clk);
    model_ext_gnt = ext_win;
    if (ext_win || !e_req)  streak = 0;
    else if (c_req && e_req && streak < 15) streak++;
    pend_v = 1'b0;
    if (exp_en) begin
      if (exp_wen == 4'h0) begin
        pend_v    = 1'b1;
        pend_ext  = ext_win;
        pend_data = ref_mem[exp_addr[10:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (exp_wen[b]) ref_mem[exp_addr[10:2]][b*8 +: 8] = exp_wdata[b*8 +: 8];
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_wen = 4'h0; c_addr = 32'h0; c_wdata = 32'h0;
    e_req = 0; e_wen = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
  endtask

  initial begin
    bit [5:0] gnt_bits, stall_bits;
    for (int i = 0; i < 512; i++) begin
      mem_arr[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
      ref_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
    end
    mem_arr[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    bus.mem_rdata = 32'h0;
    streak = 0; pend_v = 0; pend_ext = 0; pend_data = 32'h0; model_ext_gnt = 0;
    idle_inputs();
    drive_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_core_rvalid", 32'(bus.core_rvalid), 32'd0);
    check("rst_ext_rvalid",  32'(bus.ext_rvalid),  32'd0);
    check("rst_core_stall",  32'(bus.core_stall),  32'd0);
    check("rst_ext_gnt",     32'(bus.ext_gnt),     32'd0);
    check("rst_mem_en",      32'(bus.mem_en),      32'd0);
    check("rst_mem_wen",     32'(bus.mem_wen),     32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    cycle();

    // Core-only read of 0x10
    c_req = 1; c_wen = 4'h0; c_addr = 32'h10;
    cycle();
    check("t1_mem_en", 32'(obs_mem_en), 32'd1);
    check("t1_stall",  32'(obs_stall),  32'd0);
    idle_inputs();
    cycle();
    check("t1_rvalid", 32'(obs_core_rvalid), 32'd1);
    check("t1_rdata",  obs_core_rdata, 32'hDEADBEEF);
    check("t1_ext_rvalid", 32'(obs_ext_rvalid), 32'd0);

    // Ext-only write then read of 0x400
    e_req = 1; e_wen = 4'hF; e_addr = 32'h400; e_wdata = 32'hA5A5A5A5;
    cycle();
    check("t2_wr_gnt", 32'(obs_ext_gnt), 32'd1);
    e_wen = 4'h0; e_wdata = 32'h0;
    cycle();
    check("t2_rd_gnt", 32'(obs_ext_gnt), 32'd1);
    idle_inputs();
    cycle();
    check("t2_rvalid", 32'(obs_ext_rvalid), 32'd1);
    check("t2_rdata",  obs_ext_rdata, 32'hA5A5A5A5);

    // Both request continuously: ext wins only on cycle STARVE_MAX
    c_req = 1; c_addr = 32'h8; e_req = 1; e_addr = 32'hC;
    for (int i = 0; i < 6; i++) begin
      cycle();
      gnt_bits[i]   = obs_ext_gnt;
      stall_bits[i] = obs_stall;
    end
    check("t3_ext_gnt_pattern", 32'(gnt_bits),   32'b010000);
    check("t3_stall_pattern",   32'(stall_bits), 32'b010000);
    idle_inputs();
    cycle();

    // Alternating reads: core 0x0, then ext 0x4
    c_req = 1; c_addr = 32'h0;
    cycle();
    idle_inputs();
    e_req = 1; e_addr = 32'h4;
    cycle();
    check("t4_core_rvalid", 32'(obs_core_rvalid), 32'd1);
    check("t4_core_rdata",  obs_core_rdata, 32'h5A00_0000);
    idle_inputs();
    cycle();
    check("t4_ext_rvalid",  32'(obs_ext_rvalid), 32'd1);
    check("t4_ext_rdata",   obs_ext_rdata, 32'h5A01_0203);
    check("t4_core_off",    32'(obs_core_rvalid), 32'd0);

    // Byte store at 0x22
    c_req = 1; c_wen = 4'b0100; c_addr = 32'h22; c_wdata = 32'h0077_0000;
    cycle();
    check("t5_mem_wen", 32'(obs_mem_wen), 32'b0100);
    idle_inputs();
    cycle();
    check("t5_no_rvalid", 32'(obs_core_rvalid | obs_ext_rvalid), 32'd0);

    // Reset pulsed with a read in flight and the starvation counter at 3
    c_req = 1; c_addr = 32'h10; e_req = 1; e_addr = 32'h14;
    repeat (3) cycle();
    rstn = 1'b0;
    #1;
    check("t6_rvalid_dropped", 32'(bus.core_rvalid), 32'd0);
    pend_v = 0; streak = 0;
    idle_inputs();
    drive_inputs();
    @(negedge clk);
    check("t6_rst_mem_en", 32'(bus.mem_en), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    cycle();
    check("t6_post_rvalid", 32'(obs_core_rvalid), 32'd0);
    c_req = 1; c_addr = 32'h10; e_req = 1; e_addr = 32'h14;
    for (int i = 0; i < 5; i++) begin
      cycle();
      gnt_bits[i] = obs_ext_gnt;
    end
    check("t6_counter_cleared", 32'(gnt_bits[4:0]), 32'b10000);
    idle_inputs();
    cycle();

    // Randomized traffic; external fields held until granted
    for (int phase = 0; phase < 3; phase++) begin
      for (int n = 0; n < 300; n++) begin
        c_req   = (phase == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
        c_wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        c_addr  = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
        c_wdata = $urandom;
        if (!e_req || model_ext_gnt) begin
          e_req   = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
          e_wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          e_addr  = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
          e_wdata = $urandom;
        end
        cycle();
      end
    end
    idle_inputs();
    model_ext_gnt = 0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
